// File: rtl/npc_mem_pkg.sv
// npc_mem_pkg: shared types and constants for the npc memory arbiter
package npc_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam logic [7:0] IFU_WMASK = 8'h0F;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    typedef enum logic {
        IFU,
        LSU
    } owner_t;

endpackage

// File: rtl/npc_arb_rr2.sv
// npc_arb_rr2: 2-way round-robin grant, the requester not granted last wins a tie
module npc_arb_rr2
    import npc_mem_pkg::*;
(
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    input  owner_t last_grant,
    output logic   gnt_ifu,
    output logic   gnt_lsu
);

    // a lone requester always wins; on a tie the one opposite last_grant wins
    always_comb begin
        gnt_ifu = ifu_valid & (~lsu_valid | (last_grant == LSU));
        gnt_lsu = lsu_valid & (~ifu_valid | (last_grant == IFU));
    end

endmodule

// File: rtl/npc_mem_arbiter.sv
// npc_mem_arbiter: IFU/LSU arbiter onto one memory port, single outstanding transaction with watchdog
module npc_mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_resp_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_req_wen,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [7:0]        lsu_req_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t            state, state_nxt;
    owner_t            owner, last_grant;
    logic [CNT_W-1:0]  cnt;
    logic              gnt_ifu, gnt_lsu;
    logic              ifu_acc, lsu_acc, accept;
    logic              busy, resp_hit, tmo, done;

    npc_arb_rr2 u_arb (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_grant),
        .gnt_ifu    (gnt_ifu),
        .gnt_lsu    (gnt_lsu)
    );

    // handshake, completion and response routing; a response beats a same-cycle timeout
    always_comb begin
        ifu_req_ready  = (state == IDLE) & gnt_ifu & ~reset;
        lsu_req_ready  = (state == IDLE) & gnt_lsu & ~reset;
        ifu_acc        = ifu_req_valid & ifu_req_ready;
        lsu_acc        = lsu_req_valid & lsu_req_ready;
        accept         = ifu_acc | lsu_acc;
        busy           = (state == REQ) | (state == WAIT);
        resp_hit       = (state == WAIT) & mem_resp_valid;
        tmo            = busy & (cnt == CNT_MAX) & ~resp_hit;
        done           = resp_hit | tmo;
        mem_req_valid  = (state == REQ) & ~tmo;
        ifu_resp_valid = done & (owner == IFU);
        lsu_resp_valid = done & (owner == LSU);
        ifu_resp_rdata = (ifu_resp_valid & resp_hit) ? mem_resp_rdata : '0;
        lsu_resp_rdata = (lsu_resp_valid & resp_hit & ~mem_req_wen) ? mem_resp_rdata : '0;
    end

    // next-state: accept in IDLE, handshake in REQ, response or abort ends the transaction
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? REQ : IDLE;
            REQ:     state_nxt = tmo ? IDLE : (mem_req_ready ? WAIT : REQ);
            WAIT:    state_nxt = done ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    // state, ownership, watchdog counter and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= IFU;
            last_grant  <= LSU;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner      <= ifu_acc ? IFU : LSU;
                last_grant <= ifu_acc ? IFU : LSU;
                cnt        <= '0;
            end else if (busy) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (tmo) timeout_err <= 1'b1;
        end
    end

    // downstream payload, captured at accept and held for the whole transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else if (accept) begin
            mem_req_wen   <= ifu_acc ? 1'b0 : lsu_req_wen;
            mem_req_addr  <= ifu_acc ? ifu_req_addr : lsu_req_addr;
            mem_req_wdata <= ifu_acc ? '0 : lsu_req_wdata;
            mem_req_wmask <= ifu_acc ? IFU_WMASK : lsu_req_wmask;
        end
    end

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// tb_npc_mem_arbiter: scoreboard bench for the IFU/LSU memory arbiter
module tb_npc_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_req_addr, ifu_resp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
    logic [7:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        timeout_err;

    typedef struct packed {
        logic        lsu;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    npc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_rdata (ifu_resp_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wmask  (lsu_req_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_rdata (lsu_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive valids, check which side is granted, then drop the granted valid
    task automatic grant(input logic iv, input logic lv, input logic ei, input logic el, input string tag);
        ifu_req_valid = iv;
        lsu_req_valid = lv;
        @(negedge clk);
        check({tag, "_irdy"}, ifu_req_ready, ei);
        check({tag, "_lrdy"}, lsu_req_ready, el);
        tick();
        ifu_req_valid = iv & ~ei;
        lsu_req_valid = lv & ~el;
    endtask

    // memory side: stall, accept, then respond one cycle later
    task automatic serve(input int stall, input logic [31:0] rd, input logic [31:0] a, input logic w,
                         input logic [7:0] m, input logic [31:0] wd, input string tag);
        for (int i = 0; i <= stall; i++) begin
            mem_req_ready = (i == stall);
            @(negedge clk);
            check({tag, "_mv"}, mem_req_valid, 1);
            check({tag, "_ma"}, mem_req_addr, a);
            check({tag, "_mw"}, mem_req_wen, w);
            check({tag, "_mm"}, mem_req_wmask, m);
            check({tag, "_md"}, mem_req_wdata, wd);
            check({tag, "_busy"}, ifu_req_ready | lsu_req_ready, 0);
            tick();
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rd;
        @(negedge clk);
        check({tag, "_wv"}, mem_req_valid, 0);
        check({tag, "_pulse"}, ifu_resp_valid | lsu_resp_valid, 1);
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    // response monitor: every pulse must match the oldest expected response
    always @(negedge clk) begin
        if (ifu_req_ready && lsu_req_ready) check("rdy_excl", 1, 0);
        if (ifu_resp_valid || lsu_resp_valid) begin
            if (ifu_resp_valid && lsu_resp_valid) check("resp_both", 1, 0);
            if (sb.size() == 0) begin
                check("resp_unexp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_own", lsu_resp_valid, e.lsu);
                check("resp_data", lsu_resp_valid ? lsu_resp_rdata : ifu_resp_rdata, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ifu_req_valid = 1'b0;
        ifu_req_addr = '0;
        lsu_req_valid = 1'b0;
        lsu_req_wen = 1'b0;
        lsu_req_addr = '0;
        lsu_req_wdata = '0;
        lsu_req_wmask = '0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        ifu_req_valid = 1'b1;
        @(negedge clk);
        check("rst_irdy", ifu_req_ready, 0);
        check("rst_mv", mem_req_valid, 0);
        check("rst_ma", mem_req_addr, 0);
        check("rst_mm", mem_req_wmask, 0);
        check("rst_err", timeout_err, 0);
        tick();
        ifu_req_valid = 1'b0;
        reset = 1'b0;

        ifu_req_addr = 32'h100;
        lsu_req_addr = 32'h200;
        lsu_req_wen = 1'b0;
        lsu_req_wmask = 8'h0F;
        lsu_req_wdata = '0;
        sb.push_back('{lsu: 1'b0, rdata: 32'h11});
        grant(1, 1, 1, 0, "tie1");
        serve(0, 32'h11, 32'h100, 0, 8'h0F, 0, "t2a");
        ifu_req_addr = 32'h104;
        sb.push_back('{lsu: 1'b1, rdata: 32'h22});
        grant(1, 1, 0, 1, "tie2");
        serve(0, 32'h22, 32'h200, 0, 8'h0F, 0, "t2b");
        sb.push_back('{lsu: 1'b0, rdata: 32'h33});
        grant(1, 0, 1, 0, "t2c");
        serve(0, 32'h33, 32'h104, 0, 8'h0F, 0, "t2c");

        lsu_req_wen = 1'b1;
        lsu_req_addr = 32'h80000010;
        lsu_req_wdata = 32'hA5;
        lsu_req_wmask = 8'h01;
        sb.push_back('{lsu: 1'b1, rdata: 32'h0});
        grant(0, 1, 0, 1, "sb");
        lsu_req_wdata = 32'hFF;
        lsu_req_wmask = 8'h0F;
        serve(4, 32'hDEADBEEF, 32'h80000010, 1, 8'h01, 32'hA5, "sb");

        ifu_req_addr = 32'h300;
        sb.push_back('{lsu: 1'b0, rdata: 32'h0});
        grant(1, 0, 1, 0, "to");
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("to_early", ifu_resp_valid, 0);
            check("to_err0", timeout_err, 0);
            tick();
        end
        @(negedge clk);
        check("to_pulse", ifu_resp_valid, 1);
        tick();
        @(negedge clk);
        check("to_err1", timeout_err, 1);
        check("to_idle", mem_req_valid, 0);
        tick();

        ifu_req_addr = 32'h80000000;
        sb.push_back('{lsu: 1'b0, rdata: 32'h00100073});
        grant(1, 0, 1, 0, "t1");
        serve(0, 32'h00100073, 32'h80000000, 0, 8'h0F, 0, "t1");
        @(negedge clk);
        check("err_sticky", timeout_err, 1);
        tick();

        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h55;
        @(negedge clk);
        check("stray", ifu_resp_valid | lsu_resp_valid, 0);
        tick();
        mem_resp_valid = 1'b0;

        lsu_req_wen = 1'b0;
        lsu_req_addr = 32'h400;
        grant(0, 1, 0, 1, "rw");
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        reset = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h66;
        @(negedge clk);
        check("rw_resp", ifu_resp_valid | lsu_resp_valid, 0);
        check("rw_err", timeout_err, 0);
        check("rw_mv", mem_req_valid, 0);
        tick();
        mem_resp_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rw_idle", mem_req_valid, 0);
        tick();

        lsu_req_wen = 1'b1;
        lsu_req_addr = 32'h500;
        lsu_req_wdata = 32'h1234;
        lsu_req_wmask = 8'h0F;
        sb.push_back('{lsu: 1'b1, rdata: 32'h0});
        grant(0, 1, 0, 1, "post");
        serve(1, 32'h77, 32'h500, 1, 8'h0F, 32'h1234, "post");

        @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
